// File: rtl/servo_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_ramp_ctrl_if
//  Description : Position-command handshake bundle for servo_ramp_ctrl.
//                cmd_valid/cmd_pos are driven by the requester, cmd_ready by
//                the controller. A transfer happens on a clock edge where
//                cmd_valid && cmd_ready.
//  Signals     : cmd_valid (1)  command present
//                cmd_ready (1)  controller can accept a command
//                cmd_pos   (8)  target position 0..255
//  Revision    : 1.0  initial release
// ============================================================================
interface servo_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_pos;

    modport master (
        output cmd_valid,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pos,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/servo_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : servo_ramp_ctrl
//  Description : Rate-limited servo position controller. Maps 8-bit position
//                commands to pulse widths, slews the active pulse width toward
//                the target once per frame and generates the fixed-period PWM.
//                All pulse-width changes take effect on frame boundaries only.
//  Ports       : clock_clk  in   1  sole clock, rising edge
//                reset      in   1  synchronous active-high reset
//                enable     in   1  PWM request, sampled at frame boundary
//                cmd        slave   command handshake (valid/ready/pos)
//                pwm_out    out  1  registered servo PWM
//                busy       out  1  ramp in progress or command pending
//                cur_pw     out 32  pulse width currently generated (cycles)
//                frame_tick out  1  high on the last cycle of each frame
//  Config      : SERVO_RAMP_EN defined   -> step-limited slewing (STEP/frame)
//                SERVO_RAMP_EN undefined -> target applied in a single frame
//  Revision    : 1.0  initial release
// ============================================================================
module servo_ramp_ctrl #(
    parameter int unsigned PERIOD_CYC = 1000000,
    parameter int unsigned MIN_PW     = 50000,
    parameter int unsigned MAX_PW     = 100000,
    parameter int unsigned PW_PER_LSB = 196,
    parameter int unsigned STEP       = 500
) (
    input  wire logic         clock_clk,
    input  wire logic         reset,
    input  wire logic         enable,
    servo_ramp_ctrl_if.slave  cmd,
    output logic              pwm_out,
    output logic              busy,
    output logic [31:0]       cur_pw,
    output logic              frame_tick
);

`ifdef SERVO_RAMP_EN
    localparam bit          c_RAMP_ON   = 1'b1;
`else
    localparam bit          c_RAMP_ON   = 1'b0;
`endif

    // Without ramping the step limit is effectively infinite, so the same
    // stepping datapath lands on the target in one frame.
    localparam logic [31:0] c_STEP_LIM   = c_RAMP_ON ? 32'(STEP) : 32'hFFFF_FFFF;
    localparam logic [31:0] c_LAST_CNT   = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] c_CENTER_RAW = 32'(MIN_PW + 128 * PW_PER_LSB);
    localparam logic [31:0] c_CENTER     = (c_CENTER_RAW > 32'(MAX_PW)) ? 32'(MAX_PW)
                                                                        : c_CENTER_RAW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RAMP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_cur_pw;
    logic [31:0] r_target;
    logic [31:0] r_pend_tgt;
    logic        r_pend_valid;
    logic        r_pwm;

    logic        w_boundary;
    logic        w_xfer;
    logic [31:0] w_map_raw;
    logic [31:0] w_map;
    logic [31:0] w_next_tgt;
    logic [31:0] w_next_cur;

    assign w_boundary = (r_cnt == c_LAST_CNT);
    assign w_xfer     = cmd.cmd_valid && !r_pend_valid;

    assign w_map_raw  = 32'(MIN_PW) + ({24'd0, cmd.cmd_pos} * 32'(PW_PER_LSB));
    assign w_map      = (w_map_raw > 32'(MAX_PW)) ? 32'(MAX_PW) : w_map_raw;

    // A pending command becomes the target on the same boundary that the
    // step is taken, so the step already heads toward the new target.
    assign w_next_tgt = r_pend_valid ? r_pend_tgt : r_target;

    // Distances are compared before adding/subtracting so no sum can wrap.
    always_comb begin
        w_next_cur = r_cur_pw;
        if (r_cur_pw < w_next_tgt) begin
            w_next_cur = ((w_next_tgt - r_cur_pw) > c_STEP_LIM) ? (r_cur_pw + c_STEP_LIM)
                                                                : w_next_tgt;
        end else if (r_cur_pw > w_next_tgt) begin
            w_next_cur = ((r_cur_pw - w_next_tgt) > c_STEP_LIM) ? (r_cur_pw - c_STEP_LIM)
                                                                : w_next_tgt;
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset) begin
            r_cnt        <= 32'd0;
            r_pwm        <= 1'b0;
            r_state      <= S_IDLE;
            r_cur_pw     <= c_CENTER;
            r_target     <= c_CENTER;
            r_pend_tgt   <= c_CENTER;
            r_pend_valid <= 1'b0;
        end else begin
            r_cnt <= w_boundary ? 32'd0 : (r_cnt + 32'd1);
            r_pwm <= (r_state != S_IDLE) && (r_cnt < r_cur_pw);

            // Accept and consume are mutually exclusive: accepting needs the
            // slot empty, consuming needs it full.
            if (w_xfer) begin
                r_pend_valid <= 1'b1;
                r_pend_tgt   <= w_map;
            end

            if (w_boundary) begin
                if (r_pend_valid) begin
                    r_pend_valid <= 1'b0;
                end
                r_target <= w_next_tgt;
                r_cur_pw <= w_next_cur;
                if (!enable) begin
                    r_state <= S_IDLE;
                end else if (w_next_cur == w_next_tgt) begin
                    r_state <= S_HOLD;
                end else begin
                    r_state <= S_RAMP;
                end
            end
        end
    end

    assign cmd.cmd_ready = !r_pend_valid;
    assign pwm_out       = r_pwm;
    assign cur_pw        = r_cur_pw;
    assign frame_tick    = w_boundary;

`ifdef SERVO_RAMP_EN
    assign busy = r_pend_valid || (r_cur_pw != r_target);
`else
    assign busy = r_pend_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_servo_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_ramp_ctrl
//  Description : Directed self-checking bench for servo_ramp_ctrl using the
//                reduced sim parameters (frame 1000, center pulse 178).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_servo_ramp_ctrl;

    localparam int unsigned PERIOD = 1000;
    localparam int unsigned CENTER = 178;

    logic        clock_clk = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic        pwm_out;
    logic        busy;
    logic [31:0] cur_pw;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;
    int pos   = 0;   // expected frame counter value

    servo_ramp_ctrl_if u_if ();

    servo_ramp_ctrl #(
        .PERIOD_CYC (1000),
        .MIN_PW     (50),
        .MAX_PW     (305),
        .PW_PER_LSB (1),
        .STEP       (20)
    ) u_dut (
        .clock_clk  (clock_clk),
        .reset      (reset),
        .enable     (enable),
        .cmd        (u_if.slave),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .cur_pw     (cur_pw),
        .frame_tick (frame_tick)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_clk);
        #1;
        pos = (pos + 1) % PERIOD;
    endtask

    // Runs from the current position up to the next frame start, counting
    // pwm high cycles and checking frame_tick against the expected position.
    // enable is dropped when the position reaches drop_at (if >= 0).
    task automatic run_frame(input int drop_at, output int highs);
        int tick_err;
        highs    = 0;
        tick_err = 0;
        do begin
            if (pos == drop_at) enable = 1'b0;
            if (pwm_out === 1'b1) highs++;
            if (frame_tick !== (pos == PERIOD - 1)) tick_err++;
            tick();
        end while (pos != 0);
        check("frame_tick_position", 32'(tick_err), 32'd0);
    endtask

    function automatic int ramp_exp(input int start, input int tgt, input int k);
`ifdef SERVO_RAMP_EN
        int v;
        if (tgt > start) v = (start + 20 * k > tgt) ? tgt : start + 20 * k;
        else             v = (start - 20 * k < tgt) ? tgt : start - 20 * k;
        return v;
`else
        return (k > 0) ? tgt : start;
`endif
    endfunction

    initial begin
        int highs;
        int prev;
        int e;
        int err;
        int n;

        u_if.cmd_valid = 1'b0;
        u_if.cmd_pos   = 8'd0;

        // ---------------- reset ----------------
        @(posedge clock_clk);
        @(posedge clock_clk);
        #1;
        check("rst_pwm",   32'(pwm_out),      32'd0);
        check("rst_cur",   cur_pw,            32'(CENTER));
        check("rst_ready", 32'(u_if.cmd_ready), 32'd1);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_tick",  32'(frame_tick),   32'd0);
        reset = 1'b0;
        pos   = 0;

        // ---------------- enable, steady center pulses ----------------
        enable = 1'b1;
        run_frame(-1, highs);
        check("idle_frame_highs", 32'(highs), 32'd0);
        run_frame(-1, highs);
        check("center_frame1_highs", 32'(highs), 32'(CENTER));
        run_frame(-1, highs);
        check("center_frame2_highs", 32'(highs), 32'(CENTER));

        // ---------------- ramp to 255 -> 305 ----------------
        u_if.cmd_valid = 1'b1;
        u_if.cmd_pos   = 8'd255;
        tick();
        u_if.cmd_valid = 1'b0;
        check("cmd255_ready_low", 32'(u_if.cmd_ready), 32'd0);
        check("cmd255_busy",      32'(busy),           32'd1);
        prev = CENTER;
        for (int k = 1; k <= 7; k++) begin
            run_frame(-1, highs);
            check($sformatf("ramp_highs_%0d", k), 32'(highs), 32'(prev));
            e = ramp_exp(CENTER, 305, k);
            check($sformatf("ramp_cur_%0d", k), cur_pw, 32'(e));
            check($sformatf("ramp_busy_%0d", k), 32'(busy), 32'(e != 305));
            prev = e;
        end
        check("ramp_ready_after", 32'(u_if.cmd_ready), 32'd1);
        run_frame(-1, highs);
        check("max_pulse_highs", 32'(highs), 32'd305);

        // ---------------- back-to-back commands 0 then 10 ----------------
        u_if.cmd_valid = 1'b1;
        u_if.cmd_pos   = 8'd0;
        tick();
        check("b2b_first_taken", 32'(u_if.cmd_ready), 32'd0);
        u_if.cmd_pos = 8'd10;
        err = 0;
        while (pos != 0) begin
            if (u_if.cmd_ready !== 1'b0) err++;
            tick();
        end
        check("b2b_ready_low_frame", 32'(err), 32'd0);
        check("b2b_ready_after_bnd", 32'(u_if.cmd_ready), 32'd1);
        check("b2b_cur_bnd1", cur_pw, 32'(ramp_exp(305, 50, 1)));
        tick();
        u_if.cmd_valid = 1'b0;
        check("b2b_second_taken", 32'(u_if.cmd_ready), 32'd0);
        run_frame(-1, highs);
`ifdef SERVO_RAMP_EN
        check("b2b_cur_bnd2", cur_pw, 32'd265);
`else
        check("b2b_cur_bnd2", cur_pw, 32'd60);
`endif
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            run_frame(-1, highs);
            n++;
        end
        check("b2b_settle_in_bound", 32'(busy), 32'd0);
        check("b2b_final_cur", cur_pw, 32'd60);

        // ---------------- back to center ----------------
        u_if.cmd_valid = 1'b1;
        u_if.cmd_pos   = 8'd128;
        tick();
        u_if.cmd_valid = 1'b0;
        n = 0;
        do begin
            run_frame(-1, highs);
            n++;
        end while (busy === 1'b1 && n < 20);
        check("center_cur", cur_pw, 32'(CENTER));

        // ---------------- enable dropped mid-frame ----------------
        run_frame(100, highs);
        check("drop_pulse_finishes", 32'(highs), 32'(CENTER));
        run_frame(-1, highs);
        check("drop_next_frame_low", 32'(highs), 32'd0);

        // ---------------- reset mid-ramp ----------------
        enable         = 1'b1;
        u_if.cmd_valid = 1'b1;
        u_if.cmd_pos   = 8'd255;
        tick();
        u_if.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) run_frame(-1, highs);
        check("midramp_cur", cur_pw, 32'(ramp_exp(CENTER, 305, 3)));
        for (int k = 0; k < 200; k++) tick();
        check("midramp_pwm_high", 32'(pwm_out), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_pwm",   32'(pwm_out),        32'd0);
        check("midrst_cur",   cur_pw,              32'(CENTER));
        check("midrst_busy",  32'(busy),           32'd0);
        check("midrst_ready", 32'(u_if.cmd_ready), 32'd1);
        check("midrst_tick",  32'(frame_tick),     32'd0);
        reset = 1'b0;
        pos   = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
